audio_dma: RTL

AUDIO_DMA -- requirements
Module: audio_dma

---
 rtl/audio_pkg.sv | 23 ++
 rtl/audio_sample_fifo.sv | 65 ++++++
 rtl/audio_dma.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// +--------------------------------------------------------------------+
// | audio_pkg: shared types and constants for the audio DMA block.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package audio_pkg;

  localparam int unsigned AUDIO_WORD_BYTES = 4;
  localparam int unsigned AUDIO_HALF_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT      = 3'd2,
    ST_UNPACK_LO = 3'd3,
    ST_UNPACK_HI = 3'd4,
    ST_DRAIN     = 3'd5
  } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/audio_sample_fifo.sv
// +--------------------------------------------------------------------+
// | audio_sample_fifo: show-ahead synchronous sample FIFO with flush.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  // Head is gated so the output reads as zero whenever nothing is stored.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/audio_dma.sv
// +--------------------------------------------------------------------+
// | audio_dma: fetches 32-bit words and streams two samples per word.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module audio_dma
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                loop_i,
  input  logic [31:0]         base_addr_i,
  input  logic [15:0]         len_words_i,
  output logic                mem_req_o,
  output logic [31:0]         mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [31:0]         mem_rdata_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                irq_o,
  input  logic                irq_clr_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  dma_state_e    state_q, state_d;
  logic [31:0]   addr_q, addr_d, base_q, base_d, hold_q, hold_d;
  logic [15:0]   len_q, len_d, wcnt_q, wcnt_d, wcnt_inc;
  logic          loop_q, loop_d, abort_q, abort_d;
  logic          done_q, done_d, irq_q, irq_d, irq_set;

  logic                fifo_push, fifo_flush, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_wdata;
  logic [CNT_W-1:0]    fifo_count, free_cnt;
  logic                room_ok;

  // Both samples of a word are pushed only after the grant, so two free
  // slots at request time guarantee the unpack states never stall.
  assign free_cnt   = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign room_ok    = !fifo_full && (free_cnt >= CNT_W'(2));
  assign mem_req_o  = (state_q == ST_REQ) && room_ok;
  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign irq_o      = irq_q;
  assign sample_valid_o = !fifo_empty;
  assign wcnt_inc   = wcnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    base_d     = base_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    loop_d     = loop_q;
    abort_d    = abort_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    irq_set    = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    fifo_wdata = hold_q[SAMPLE_W-1:0];

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start_i) begin
          if (len_words_i != 16'd0) begin
            base_d  = base_addr_i;
            addr_d  = base_addr_i;
            len_d   = len_words_i;
            loop_d  = loop_i;
            wcnt_d  = 16'd0;
            state_d = ST_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_o && mem_gnt_i) begin
          // A stop racing the grant still has to retire the accepted read.
          abort_d = stop_i;
          state_d = ST_WAIT;
        end else if (stop_i) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          if (abort_q || stop_i) begin
            abort_d    = 1'b0;
            fifo_flush = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            hold_d  = mem_rdata_i;
            state_d = ST_UNPACK_LO;
          end
        end else if (stop_i) begin
          abort_d = 1'b1;
        end
      end
      ST_UNPACK_LO: begin
        if (stop_i) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          fifo_push = 1'b1;
          state_d   = ST_UNPACK_HI;
        end
      end
      ST_UNPACK_HI: begin
        if (stop_i) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          fifo_push  = 1'b1;
          fifo_wdata = hold_q[AUDIO_HALF_W +: SAMPLE_W];
          addr_d     = addr_q + 32'(AUDIO_WORD_BYTES);
          wcnt_d     = wcnt_inc;
          if (wcnt_inc < len_q) begin
            state_d = ST_REQ;
          end else if (loop_q) begin
            addr_d  = base_q;
            wcnt_d  = 16'd0;
            irq_set = 1'b1;
            state_d = ST_REQ;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (stop_i) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end else if (fifo_empty) begin
          done_d  = 1'b1;
          irq_set = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    irq_d = irq_set ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      loop_q  <= 1'b0;
      abort_q <= 1'b0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      loop_q  <= loop_d;
      abort_q <= abort_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
    end
  end

  audio_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (sample_ready_i),
    .data_o  (sample_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

`default_nettype wire
